comb_user_scheduler: RTL and testbench

- Slot-level controller that sequences per-user HARQ combining.
- Walks the active-user mask in ascending index order and issues one combine request per user to the combine FSM.
- Tracks ownership of the two combine buffers (ping/pong) and hands each finished buffer to the SENDHARQ engine with its Ncb and ping-pong indicator.
- Sits between slot control and the combine/SENDHARQ datapath.

---
 rtl/comb_user_scheduler.sv | 153 +++++++++++++++
 tb/tb_comb_user_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_user_scheduler.sv
// comb_user_scheduler: walks the active-user mask, issues one combine per user into ping/pong buffers and hands each filled buffer to SENDHARQ.
// Optional watchdog macro: COMB_SCHED_TIMEOUT_EN (adds o_err_timeout).
// Ports: i_core_clk, i_rx_rstn/i_rx_fsm_rstn (async active-low resets), i_slot_start/i_user_valid_mask/i_users_ncb (slot control),
//        o_combine_request/o_combine_user_index/i_combine_comp (combine FSM), o_sendharq_* / i_sendharq_comp (SENDHARQ engine),
//        o_busy/o_users_done_mask/o_slot_done/o_err_overrun (status).
module comb_user_scheduler #(
  parameter int NUM_USERS      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   i_core_clk,
  input  logic                   i_rx_rstn,
  input  logic                   i_rx_fsm_rstn,
  input  logic                   i_slot_start,
  input  logic [NUM_USERS-1:0]   i_user_valid_mask,
  input  logic [16*NUM_USERS-1:0] i_users_ncb,
  output logic                   o_combine_request,
  output logic [3:0]             o_combine_user_index,
  input  logic                   i_combine_comp,
  output logic                   o_sendharq_request,
  output logic                   o_sendharq_pingpong,
  output logic [15:0]            o_sendharq_ncb,
  input  logic                   i_sendharq_comp,
  output logic                   o_busy,
  output logic [NUM_USERS-1:0]   o_users_done_mask,
  output logic                   o_slot_done,
  output logic                   o_err_overrun
`ifdef COMB_SCHED_TIMEOUT_EN
  ,
  output logic                   o_err_timeout
`endif
);
  typedef enum logic [2:0] {IDLE, SEARCH, REQ, WAIT_COMB, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_USERS-1:0] pend_q, pend_d, done_q, done_d, idx_oh;
  logic [3:0] idx_q, idx_d, sel;
  logic [1:0][15:0] ncb_q, ncb_d;
  logic [1:0] occ_q, occ_d;
  logic wr_q, wr_d, rd_q, rd_d, hb_q, hb_d, sreq_q, sreq_d, pp_q, pp_d;
  logic [15:0] sncb_q, sncb_d, ncb_sel;
  logic found, comb_ok, send_ok, tmo, rst_n;
  assign rst_n = i_rx_rstn & i_rx_fsm_rstn;
  assign idx_oh = {{(NUM_USERS-1){1'b0}}, 1'b1} << idx_q;
`ifdef COMB_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  assign wd_d = state_q == WAIT_COMB ? wd_q + 16'd1 : '0;
  assign tmo = state_q == WAIT_COMB && !i_combine_comp && wd_q == WD_LAST;
  assign o_err_timeout = tmo;
  always_ff @(posedge i_core_clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else wd_q <= wd_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    sel = '0;
    ncb_sel = '0;
    found = 1'b0;
    for (int i = NUM_USERS - 1; i >= 0; i--)
      if (pend_q[i]) begin
        sel = 4'(i);
        ncb_sel = i_users_ncb[16*i +: 16];
        found = 1'b1;
      end
    comb_ok = state_q == WAIT_COMB && i_combine_comp;
    send_ok = hb_q && i_sendharq_comp;
    wr_d = wr_q ^ comb_ok;
    rd_d = rd_q ^ send_ok;
    occ_d = (comb_ok && !send_ok && occ_q != 2'd2) ? occ_q + 2'd1 :
            (send_ok && !comb_ok && occ_q != 2'd0) ? occ_q - 2'd1 : occ_q;
    hb_d = hb_q && !send_ok;
    sreq_d = 1'b0;
    pp_d = pp_q;
    sncb_d = sncb_q;
    // Idle engine with a filled buffer: launch it; the request is registered together with its buffer info.
    if (!hb_q && occ_q != 2'd0) begin
      hb_d = 1'b1;
      sreq_d = 1'b1;
      pp_d = rd_q;
      sncb_d = ncb_q[rd_q];
    end
    state_d = state_q;
    pend_d = pend_q;
    done_d = done_q;
    idx_d = idx_q;
    ncb_d = ncb_q;
    case (state_q)
      IDLE:
        if (i_slot_start) begin
          pend_d = i_user_valid_mask;
          done_d = '0;
          state_d = SEARCH;
        end
      SEARCH:
        if (!found) state_d = DRAIN;
        else if (occ_q != 2'd2) begin
          idx_d = sel;
          ncb_d[wr_q] = ncb_sel;
          state_d = REQ;
        end
      REQ: state_d = WAIT_COMB;
      WAIT_COMB:
        if (comb_ok) begin
          pend_d = pend_q & ~idx_oh;
          done_d = done_q | idx_oh;
          state_d = SEARCH;
        end else if (tmo) begin
          pend_d = pend_q & ~idx_oh;
          state_d = SEARCH;
        end
      DRAIN: state_d = (occ_q == 2'd0 && !hb_q) ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_core_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q <= '0;
      done_q <= '0;
      idx_q <= '0;
      ncb_q <= '0;
      occ_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      hb_q <= 1'b0;
      sreq_q <= 1'b0;
      pp_q <= 1'b0;
      sncb_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      done_q <= done_d;
      idx_q <= idx_d;
      ncb_q <= ncb_d;
      occ_q <= occ_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      hb_q <= hb_d;
      sreq_q <= sreq_d;
      pp_q <= pp_d;
      sncb_q <= sncb_d;
    end
  assign o_combine_request = state_q == REQ;
  assign o_combine_user_index = idx_q;
  assign o_sendharq_request = sreq_q;
  assign o_sendharq_pingpong = pp_q;
  assign o_sendharq_ncb = sncb_q;
  assign o_busy = state_q != IDLE;
  assign o_users_done_mask = done_q;
  assign o_slot_done = state_q == DONE;
  assign o_err_overrun = i_slot_start && state_q != IDLE;
endmodule

// File: tb/tb_comb_user_scheduler.sv
// tb_comb_user_scheduler: table vectors, hand-written corner sequences and random slots checked against a transaction-level model.
module tb_comb_user_scheduler;
  localparam int N = 8;
  logic i_core_clk = 1'b0, i_rx_rstn = 1'b0, i_rx_fsm_rstn = 1'b1, i_slot_start = 1'b0;
  logic [N-1:0] i_user_valid_mask = '0;
  logic [16*N-1:0] i_users_ncb = '0;
  logic o_combine_request, i_combine_comp, o_sendharq_request, o_sendharq_pingpong, i_sendharq_comp;
  logic o_busy, o_slot_done, o_err_overrun;
  logic [3:0] o_combine_user_index;
  logic [15:0] o_sendharq_ncb;
  logic [N-1:0] o_users_done_mask;
  logic comb_auto = 1'b0, comb_man = 1'b0, send_auto = 1'b0, send_man = 1'b0, auto_en = 1'b0;
  bit rnd = 1'b0;
  int cd = 1, sd = 1;
  int checks = 0, errors = 0, cyc = 0, tot = 0;
  int q_idx[$], q_icyc[$], q_pp[$], q_ncb[$], q_scyc[$];
  assign i_combine_comp = comb_auto | comb_man;
  assign i_sendharq_comp = send_auto | send_man;
  comb_user_scheduler #(.NUM_USERS(N), .TIMEOUT_CYCLES(65535)) dut (
    .i_core_clk(i_core_clk), .i_rx_rstn(i_rx_rstn), .i_rx_fsm_rstn(i_rx_fsm_rstn),
    .i_slot_start(i_slot_start), .i_user_valid_mask(i_user_valid_mask), .i_users_ncb(i_users_ncb),
    .o_combine_request(o_combine_request), .o_combine_user_index(o_combine_user_index),
    .i_combine_comp(i_combine_comp), .o_sendharq_request(o_sendharq_request),
    .o_sendharq_pingpong(o_sendharq_pingpong), .o_sendharq_ncb(o_sendharq_ncb),
    .i_sendharq_comp(i_sendharq_comp), .o_busy(o_busy), .o_users_done_mask(o_users_done_mask),
    .o_slot_done(o_slot_done), .o_err_overrun(o_err_overrun));
  always #5 i_core_clk = ~i_core_clk;
  always @(posedge i_core_clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge i_core_clk);
    if (o_combine_request) begin
      q_idx.push_back(int'(o_combine_user_index));
      q_icyc.push_back(cyc);
    end
    if (o_sendharq_request) begin
      q_pp.push_back(int'(o_sendharq_pingpong));
      q_ncb.push_back(int'(o_sendharq_ncb));
      q_scyc.push_back(cyc);
    end
  end
  initial forever begin
    @(negedge i_core_clk);
    if (auto_en && o_combine_request) begin
      repeat (rnd ? $urandom_range(1, 6) : cd) @(negedge i_core_clk);
      comb_auto = 1'b1;
      @(negedge i_core_clk);
      comb_auto = 1'b0;
    end
  end
  initial forever begin
    @(negedge i_core_clk);
    if (auto_en && o_sendharq_request) begin
      repeat (rnd ? $urandom_range(1, 6) : sd) @(negedge i_core_clk);
      send_auto = 1'b1;
      @(negedge i_core_clk);
      send_auto = 1'b0;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic start_slot(input logic [7:0] m, input logic [127:0] ncb, output int s);
    i_user_valid_mask = m;
    i_users_ncb = ncb;
    i_slot_start = 1'b1;
    s = cyc;
    @(negedge i_core_clk);
    i_slot_start = 1'b0;
  endtask
  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 3000 && !o_slot_done; k++) @(negedge i_core_clk);
    if (o_slot_done) dc = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL slot_done_wait got none expected pulse within 3000 cycles");
    end
    @(negedge i_core_clk);
  endtask
  task automatic wait_req();
    int k;
    for (k = 0; k < 200 && !o_combine_request; k++) @(negedge i_core_clk);
    if (!o_combine_request) begin
      checks++;
      errors++;
      $display("FAIL combine_request_wait got none expected pulse within 200 cycles");
    end
  endtask
  task automatic pulse_comb();
    comb_man = 1'b1;
    @(negedge i_core_clk);
    comb_man = 1'b0;
  endtask
  task automatic check_model(input string tag, input logic [7:0] m, input logic [127:0] ncb, input int bi, input int bs, input int s);
    int e[$];
    int nc, ns;
    for (int i = 0; i < N; i++) if (m[i]) e.push_back(i);
    nc = q_idx.size() - bi;
    ns = q_pp.size() - bs;
    chk({tag, "_ncomb"}, nc, e.size());
    chk({tag, "_nsend"}, ns, e.size());
    for (int k = 0; k < e.size(); k++) begin
      if (k < nc) chk({tag, "_idx"}, q_idx[bi+k], e[k]);
      if (k < ns) begin
        chk({tag, "_pingpong"}, q_pp[bs+k], (tot + k) % 2);
        chk({tag, "_ncb"}, q_ncb[bs+k], ncb[16*e[k] +: 16]);
      end
    end
    if (nc > 0) chk({tag, "_req_latency"}, q_icyc[bi] - s, 2);
    chk({tag, "_done_mask"}, o_users_done_mask, m);
    tot += e.size();
  endtask
  typedef struct {
    logic [7:0] mask;
    int cd;
    int sd;
    int exp_n;
    int exp_first;
    logic [7:0] exp_done;
  } vec_t;
  vec_t tbl[5];
  initial begin
    int s, dc, bi, bs, c;
    logic [127:0] ncb;
    logic [7:0] m;
    tbl[0] = '{8'h00, 1, 1, 0, 0, 8'h00};
    tbl[1] = '{8'h05, 10, 4, 2, 0, 8'h05};
    tbl[2] = '{8'h80, 2, 2, 1, 7, 8'h80};
    tbl[3] = '{8'hFF, 1, 1, 8, 0, 8'hFF};
    tbl[4] = '{8'h12, 3, 6, 2, 1, 8'h12};
    repeat (3) @(negedge i_core_clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_comb_req", {o_combine_request, o_combine_user_index}, 0);
    chk("reset_send", {o_sendharq_request, o_sendharq_pingpong, o_sendharq_ncb}, 0);
    chk("reset_status", {o_users_done_mask, o_slot_done, o_err_overrun}, 0);
    i_rx_rstn = 1'b1;
    @(negedge i_core_clk);
    auto_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      cd = tbl[r].cd;
      sd = tbl[r].sd;
      for (int k = 0; k < N; k++) ncb[16*k +: 16] = 16'(100 * k + 7);
      if (tbl[r].mask == 8'h05) begin
        ncb[15:0] = 16'd1024;
        ncb[47:32] = 16'd512;
      end
      bi = q_idx.size();
      bs = q_pp.size();
      start_slot(tbl[r].mask, ncb, s);
      wait_done(dc);
      chk("tbl_ncomb", q_idx.size() - bi, tbl[r].exp_n);
      if (tbl[r].exp_n > 0) chk("tbl_first_idx", q_idx[bi], tbl[r].exp_first);
      else chk("tbl_empty_done_cycle", dc - s, 3);
      chk("tbl_done_mask", o_users_done_mask, tbl[r].exp_done);
      check_model("tbl", tbl[r].mask, ncb, bi, bs, s);
    end
    auto_en = 1'b0;
    for (int k = 0; k < N; k++) ncb[16*k +: 16] = 16'($urandom);
    bi = q_idx.size();
    bs = q_pp.size();
    start_slot(8'h07, ncb, s);
    wait_req();
    repeat (3) @(negedge i_core_clk);
    pulse_comb();
    wait_req();
    repeat (3) @(negedge i_core_clk);
    pulse_comb();
    repeat (20) @(negedge i_core_clk);
    chk("stall_nreq", q_idx.size() - bi, 2);
    chk("stall_nsend", q_pp.size() - bs, 1);
    chk("stall_busy", o_busy, 1);
    c = cyc;
    send_man = 1'b1;
    @(negedge i_core_clk);
    send_man = 1'b0;
    auto_en = 1'b1;
    wait_done(dc);
    if (q_idx.size() - bi > 2) chk("stall_resume_latency", q_icyc[bi+2] - c, 2);
    check_model("stall", 8'h07, ncb, bi, bs, s);
    auto_en = 1'b0;
    bi = q_idx.size();
    bs = q_pp.size();
    start_slot(8'h03, ncb, s);
    wait_req();
    repeat (2) @(negedge i_core_clk);
    pulse_comb();
    wait_req();
    repeat (3) @(negedge i_core_clk);
    c = cyc;
    comb_man = 1'b1;
    send_man = 1'b1;
    @(negedge i_core_clk);
    comb_man = 1'b0;
    send_man = 1'b0;
    auto_en = 1'b1;
    wait_done(dc);
    if (q_pp.size() - bs > 1) chk("simul_send_latency", q_scyc[bs+1] - c, 2);
    check_model("simul", 8'h03, ncb, bi, bs, s);
    auto_en = 1'b0;
    bi = q_idx.size();
    bs = q_pp.size();
    start_slot(8'h0A, ncb, s);
    wait_req();
    repeat (2) @(negedge i_core_clk);
    i_user_valid_mask = 8'hFF;
    i_slot_start = 1'b1;
    #1;
    chk("overrun_pulse", o_err_overrun, 1);
    chk("overrun_index", o_combine_user_index, 1);
    @(negedge i_core_clk);
    i_slot_start = 1'b0;
    #1;
    chk("overrun_clear", o_err_overrun, 0);
    @(negedge i_core_clk);
    pulse_comb();
    auto_en = 1'b1;
    wait_done(dc);
    check_model("overrun", 8'h0A, ncb, bi, bs, s);
    auto_en = 1'b0;
    start_slot(8'h06, ncb, s);
    wait_req();
    repeat (2) @(negedge i_core_clk);
    i_rx_fsm_rstn = 1'b0;
    #1;
    chk("fsmrst_comb", {o_combine_request, o_combine_user_index, o_busy}, 0);
    chk("fsmrst_send", {o_sendharq_request, o_sendharq_pingpong, o_sendharq_ncb}, 0);
    @(negedge i_core_clk);
    chk("fsmrst_status", {o_users_done_mask, o_slot_done, o_err_overrun, o_busy}, 0);
    i_rx_fsm_rstn = 1'b1;
    tot = 0;
    @(negedge i_core_clk);
    comb_man = 1'b1;
    send_man = 1'b1;
    @(negedge i_core_clk);
    comb_man = 1'b0;
    send_man = 1'b0;
    repeat (3) @(negedge i_core_clk);
    chk("spurious_idle", {o_busy, o_sendharq_request, o_combine_request}, 0);
    auto_en = 1'b1;
    bi = q_idx.size();
    bs = q_pp.size();
    start_slot(8'h03, ncb, s);
    wait_done(dc);
    check_model("after_rst", 8'h03, ncb, bi, bs, s);
    rnd = 1'b1;
    for (int r = 0; r < 25; r++) begin
      m = 8'($urandom);
      for (int k = 0; k < N; k++) ncb[16*k +: 16] = 16'($urandom);
      bi = q_idx.size();
      bs = q_pp.size();
      start_slot(m, ncb, s);
      wait_done(dc);
      check_model("rand", m, ncb, bi, bs, s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
